// File: rtl/computer_system_pio_in_irq_if.sv
// Avalon-MM slave bus bundle for the input PIO.
// The fabric drives the master side and the PIO drives the slave side.
interface computer_system_pio_in_irq_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (output address, chipselect, write_n, writedata, input readdata);
  modport slave  (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/computer_system_pio_in_irq.sv
// Parametrised Avalon-MM input PIO: it synchronises the inputs, latches per-bit edges
// (write-1-to-clear), applies an interrupt mask and drives a level irq.
module computer_system_pio_in_irq #(
  parameter int DATA_WIDTH  = 8,
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_TYPE   = 0,
  parameter int IRQ_MODE    = 1
) (
  input  logic                          clk,
  input  logic                          reset_n,
  computer_system_pio_in_irq_if.slave   bus,
  input  logic [DATA_WIDTH-1:0]         in_port,
  output logic                          irq
);

  localparam int ARM_COUNT = SYNC_STAGES + 1;
  localparam int ARM_W     = $clog2(ARM_COUNT + 1);

  logic [SYNC_STAGES-1:0][DATA_WIDTH-1:0] sync_q;
  logic [DATA_WIDTH-1:0] sync;
  logic [DATA_WIDTH-1:0] prev_q;
  logic [ARM_W-1:0]      arm_q, arm_d;
  logic                  armed;
  logic [DATA_WIDTH-1:0] mask_q, mask_d;
  logic [DATA_WIDTH-1:0] ec_q, ec_d;
  logic [DATA_WIDTH-1:0] edge_det;
  logic [DATA_WIDTH-1:0] clr;
  logic [31:0]           rd_q, rd_d;
  logic                  wr_en;
  logic                  unused_wd;

  assign sync      = sync_q[SYNC_STAGES-1];
  assign armed     = (arm_q == ARM_W'(ARM_COUNT));
  assign wr_en     = bus.chipselect & ~bus.write_n;
  assign unused_wd = &{1'b0, bus.writedata};

  genvar gi;
  generate
    for (gi = 0; gi < DATA_WIDTH; gi++) begin : g_edge
      if (EDGE_TYPE == 0) begin : g_rise
        assign edge_det[gi] = sync[gi] & ~prev_q[gi];
      end else if (EDGE_TYPE == 1) begin : g_fall
        assign edge_det[gi] = ~sync[gi] & prev_q[gi];
      end else begin : g_any
        assign edge_det[gi] = sync[gi] ^ prev_q[gi];
      end
    end
  endgenerate

  always_comb begin
    arm_d  = armed ? arm_q : arm_q + 1'b1;
    mask_d = mask_q;
    clr    = '0;
    if (wr_en && bus.address == 2'd2) mask_d = bus.writedata[DATA_WIDTH-1:0];
    if (wr_en && bus.address == 2'd3) clr = bus.writedata[DATA_WIDTH-1:0];
    // Set is applied after clear so a coincident edge is never lost.
    ec_d = (ec_q & ~clr) | (edge_det & {DATA_WIDTH{armed}});
    rd_d = '0;
    case (bus.address)
      2'd0:    rd_d[DATA_WIDTH-1:0] = sync;
      2'd2:    rd_d[DATA_WIDTH-1:0] = mask_q;
      2'd3:    rd_d[DATA_WIDTH-1:0] = ec_q;
      default: rd_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
      prev_q <= '0;
      arm_q  <= '0;
      mask_q <= '0;
      ec_q   <= '0;
      rd_q   <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], in_port};
      prev_q <= sync;
      arm_q  <= arm_d;
      mask_q <= mask_d;
      ec_q   <= ec_d;
      rd_q   <= rd_d;
    end
  end

  assign bus.readdata = rd_q;

  generate
    if (IRQ_MODE == 0) begin : g_irq_level
      assign irq = |(sync & mask_q);
    end else begin : g_irq_edge
      assign irq = |(ec_q & mask_q);
    end
  endgenerate

endmodule

// File: doc/computer_system_pio_in_irq.md
# computer_system_pio_in_irq

Parametrised Avalon-MM input PIO slave for the Computer_System Qsys fabric. It is the successor to the fixed 8-bit polled input port. The block adds configurable width, an input synchroniser, per-bit edge capture with write-1-to-clear, an interrupt mask and an `irq` output. The HPS/Nios software can therefore take interrupts on external buttons and status lines instead of polling them.

## Interface
Parameters:
- `DATA_WIDTH`, default 8: number of input bits, legal range 1..32.
- `SYNC_STAGES`, default 2: synchroniser flop depth, legal range 2..4.
- `EDGE_TYPE`, default 0: edge detected. 0 = rising, 1 = falling, 2 = any.
- `IRQ_MODE`, default 1: 0 = level, so `irq` = OR of (synced data & mask). 1 = edge, so `irq` = OR of (edgecapture & mask).

Ports:
- `clk`, in, 1: system clock. All state is on its rising edge.
- `reset_n`, in, 1: reset, asynchronous, active-low.
- `address`, in, 2: word address. 0 = data, 1 = reserved, 2 = irqmask, 3 = edgecapture.
- `chipselect`, in, 1: slave select.
- `write_n`, in, 1: active-low write strobe, qualified by `chipselect`.
- `writedata`, in, 32: write data.
- `in_port`, in, `DATA_WIDTH`: asynchronous external inputs.
- `readdata`, out, 32: registered read data.
- `irq`, out, 1: interrupt request, active-high, level.

## Operation
- **Synchroniser:** `in_port` passes through `SYNC_STAGES` flops, producing `sync`. A further register `prev` holds the previous `sync`.
- **Edge detect (per bit):**
  - Rising: `sync & ~prev`.
  - Falling: `~sync & prev`.
  - Any: `sync ^ prev`.
- **Arm counter:**
  - After reset deassertion, edge detection is gated off until `SYNC_STAGES`+1 clocks have elapsed.
  - This prevents spurious capture of lines that are already high at reset.
  - The counter saturates once it has armed the detector.
- **edgecapture[DATA_WIDTH-1:0]:**
  - A bit sets on a detected edge while armed.
  - A write (`chipselect` & ~`write_n`) to address 3 clears every bit where `writedata`=1.
  - If a set and a clear hit the same bit in the same cycle, the set wins. No event is ever lost.
- **irqmask[DATA_WIDTH-1:0]:**
  - A write to address 2 loads `writedata[DATA_WIDTH-1:0]`.
  - It is read back unchanged.
- **Ignored writes:** writes to addresses 0 and 1 are ignored. `writedata` bits at or above `DATA_WIDTH` are ignored.
- **Read mux (registered every clk, independent of `chipselect`):**
  - Address 0: `sync`.
  - Address 1: 0.
  - Address 2: irqmask.
  - Address 3: edgecapture.
  - Bits 31..`DATA_WIDTH` are always 0.
- **irq:** combinational from registered state, per `IRQ_MODE`. There are no glitches from bus inputs.
- **Reset values:** on `reset_n`=0, all of the following go to 0 immediately and asynchronously: the sync chain, `prev`, arm counter, irqmask, edgecapture, `readdata` and `irq`. A reset mid-operation discards pending captures.

## Timing
- **Read latency:** 1 clock. `readdata` reflects the `address` sampled at the preceding edge. This gives a fixed wait-free Avalon read.
- **Write:** takes effect at the clk edge where it is sampled. A read of the same register on the next cycle returns the new value.
- **Input to data read:** an `in_port` change setting up before edge 1 appears in `sync` after edge `SYNC_STAGES`. It appears in `readdata` (address 0) after edge `SYNC_STAGES`+1.
- **Input to edge:** edgecapture sets at edge `SYNC_STAGES`+1. In edge mode, `irq` asserts in that same cycle if the bit is unmasked.
- **Level mode:** `irq` follows `sync` & mask with no additional delay.
- **Clearing:** `irq` deasserts in the cycle after the clearing write's edge, unless another unmasked bit is still set.
- **Minimum pulse:** input pulses must be at least 1 clk wide to be guaranteed captured.

## Test plan
- **Reset with input high:** defaults; hold `in_port`=8'hFF through reset and release. Required: edgecapture stays 0, `irq`=0, and an address 0 read returns 32'h000000FF.
- **Edge capture latency:** rising edge on bit 3 with mask 8'h08, in edge mode. Required: edgecapture=8'h08 and `irq`=1 exactly 3 clocks after the input change. Then write 8'h08 to address 3. Required: `irq`=0 on the next cycle.
- **Masked bit:** as above but with mask 8'h00. Required: edgecapture=8'h08 while `irq` stays 0. Then write mask 8'h08. Required: `irq`=1 on the next cycle.
- **Set versus clear collision:** clear write to address 3 lands in the same cycle as a new edge on the same bit. Required: the bit remains 1.
- **Width, edge type and level mode:** `DATA_WIDTH`=12, `EDGE_TYPE`=2, `IRQ_MODE`=0. Toggle bit 11 high then low. Required: edgecapture=12'h800 and `readdata[31:12]`=0. `irq` tracks bit 11 & mask.
- **Asynchronous reset mid-operation:** pulse `reset_n` low with captures pending. Required: all outputs and registers are 0 in the same cycle, with no clock needed.
